// File: rtl/text_line_scheduler_pkg.sv
// Shared types and constants for the text line scheduler.
// Holds the command and FSM encodings and the blank-cell character.
package text_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE  = 2'b00,
    CMD_SETCUR = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_NOP    = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/text_line_scheduler_if.sv
// Processor-side command port of the text line scheduler (valid/ready).
// The master issues commands; the scheduler is the slave.
interface text_line_scheduler_if #(
  parameter int NUM_CHARS = 16
) ();
  import text_pkg::*;

  localparam int POS_W = $clog2(NUM_CHARS);

  logic             wr_valid;
  logic             wr_ready;
  cmd_t             wr_cmd;
  logic [7:0]       wr_char;
  logic [POS_W-1:0] wr_pos;

  modport master (
    output wr_valid,
    output wr_cmd,
    output wr_char,
    output wr_pos,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_cmd,
    input  wr_char,
    input  wr_pos,
    output wr_ready
  );

endinterface

// File: rtl/text_cell_decode.sv
// Combinational pixel-to-cell decoder: tells whether a pixel falls inside the
// text line, which cell it belongs to, and that cell's left pixel column.
module text_cell_decode #(
  parameter int NUM_CHARS = 16,
  parameter int CHAR_W    = 16,
  parameter int CHAR_H    = 16,
  parameter int X0        = 106,
  parameter int Y0        = 80
) (
  input  logic [12:0]                  counterX,
  input  logic [12:0]                  counterY,
  output logic                         in_line,
  output logic [$clog2(NUM_CHARS)-1:0] idx,
  output logic [9:0]                   cell_x
);

  localparam int IDX_W = $clog2(NUM_CHARS);
  localparam int SH    = $clog2(CHAR_W);

  localparam logic [12:0] X_LO = 13'(X0);
  localparam logic [12:0] X_HI = 13'(X0 + NUM_CHARS * CHAR_W);
  localparam logic [12:0] Y_LO = 13'(Y0);
  localparam logic [12:0] Y_HI = 13'(Y0 + CHAR_H);

  logic [12:0] dx;
  logic [12:0] origin;

  assign in_line = (counterX >= X_LO) && (counterX < X_HI) &&
                   (counterY >= Y_LO) && (counterY < Y_HI);

  // Outside the line dx wraps; callers gate idx and cell_x with in_line.
  assign dx     = counterX - X_LO;
  assign idx    = IDX_W'(dx >> SH);
  assign origin = X_LO + (13'(idx) << SH);
  assign cell_x = 10'(origin);

endmodule

// File: rtl/text_line_scheduler.sv
// Drives one printChar renderer across a line of character cells. Commands fill
// a shadow buffer that is copied to the display buffer at vertical-blank start.
module text_line_scheduler
  import text_pkg::*;
#(
  parameter int NUM_CHARS = 16,
  parameter int CHAR_W    = 16,
  parameter int CHAR_H    = 16,
  parameter int X0        = 106,
  parameter int Y0        = 80,
  parameter int V_ACTIVE  = 480
) (
  input  logic                         clk,
  input  logic                         botonRST,
  input  logic [12:0]                  counterX,
  input  logic [12:0]                  counterY,
  text_line_scheduler_if.slave         wr,
  output logic [7:0]                   char_code,
  output logic [9:0]                   char_x,
  output logic [9:0]                   char_y,
  output logic                         cell_active,
  output logic [$clog2(NUM_CHARS)-1:0] cursor,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_CHARS);

  state_t           state;
  state_t           next_state;
  logic [7:0]       shadow  [NUM_CHARS];
  logic [7:0]       display [NUM_CHARS];
  logic [IDX_W-1:0] clr_idx;
  logic             dirty;
  logic             commit_pending;
  logic             ready_q;

  logic             vblank;
  logic             fire;
  logic             last_clear;
  logic             in_line;
  logic [IDX_W-1:0] idx;
  logic [9:0]       cell_x;

  assign vblank      = (counterY == 13'(V_ACTIVE)) && (counterX == 13'd0);
  assign wr.wr_ready = ready_q && (state == IDLE);
  assign fire        = wr.wr_valid && wr.wr_ready;
  assign last_clear  = (clr_idx == IDX_W'(NUM_CHARS - 1));
  assign busy        = (state != IDLE);

  text_cell_decode #(
    .NUM_CHARS (NUM_CHARS),
    .CHAR_W    (CHAR_W),
    .CHAR_H    (CHAR_H),
    .X0        (X0),
    .Y0        (Y0)
  ) u_decode (
    .counterX (counterX),
    .counterY (counterY),
    .in_line  (in_line),
    .idx      (idx),
    .cell_x   (cell_x)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (botonRST) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fire && wr.wr_cmd == CMD_CLEAR)
          next_state = CLEAR;
        else if (vblank && (dirty || (fire && wr.wr_cmd == CMD_WRITE)))
          next_state = COMMIT;
      end
      CLEAR: begin
        if (last_clear)
          next_state = (commit_pending || vblank) ? COMMIT : IDLE;
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: both character buffers are flop arrays with a real reset, because the
  // line must read as blanks from the first frame after reset.
  always_ff @(posedge clk) begin
    if (botonRST) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        shadow[i]  <= ASCII_SPACE;
        display[i] <= ASCII_SPACE;
      end
      cursor         <= '0;
      dirty          <= 1'b0;
      clr_idx        <= '0;
      commit_pending <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        IDLE: begin
          if (fire) begin
            case (wr.wr_cmd)
              CMD_WRITE: begin
                shadow[cursor] <= wr.wr_char;
                cursor         <= cursor + 1'b1;
                dirty          <= 1'b1;
              end
              CMD_SETCUR: cursor <= wr.wr_pos;
              CMD_CLEAR: begin
                clr_idx <= '0;
                // A blank started on the vblank edge still owes this frame a commit.
                if (vblank) commit_pending <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          shadow[clr_idx] <= ASCII_SPACE;
          clr_idx         <= clr_idx + 1'b1;
          if (vblank) commit_pending <= 1'b1;
          if (last_clear) begin
            cursor <= '0;
            dirty  <= 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_CHARS; i++) display[i] <= shadow[i];
          dirty          <= 1'b0;
          commit_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Render path reads only the display buffer, one cycle behind the pixel.
  always_ff @(posedge clk) begin
    if (botonRST) begin
      cell_active <= 1'b0;
      char_code   <= ASCII_SPACE;
      char_x      <= 10'(X0);
      char_y      <= 10'(Y0);
    end else begin
      cell_active <= in_line;
      char_code   <= in_line ? display[idx] : ASCII_SPACE;
      char_x      <= in_line ? cell_x : 10'(X0);
      char_y      <= 10'(Y0);
    end
  end

endmodule

// File: tb/tb_text_line_scheduler.sv
// Scoreboard bench for text_line_scheduler: a transaction-level model predicts
// every cycle's render and status outputs; a monitor compares them to the DUT.
module tb_text_line_scheduler;
  import text_pkg::*;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int X0 = 106;
  localparam int Y0 = 80;
  localparam int VA = 480;

  logic        clk = 1'b0;
  logic        botonRST;
  logic [12:0] counterX;
  logic [12:0] counterY;
  logic [7:0]  char_code;
  logic [9:0]  char_x;
  logic [9:0]  char_y;
  logic        cell_active;
  logic [3:0]  cursor;
  logic        busy;

  text_line_scheduler_if #(.NUM_CHARS(N)) wr_if ();

  text_line_scheduler #(
    .NUM_CHARS (N), .CHAR_W (W), .CHAR_H (H),
    .X0 (X0), .Y0 (Y0), .V_ACTIVE (VA)
  ) dut (
    .clk         (clk),
    .botonRST    (botonRST),
    .counterX    (counterX),
    .counterY    (counterY),
    .wr          (wr_if.slave),
    .char_code   (char_code),
    .char_x      (char_x),
    .char_y      (char_y),
    .cell_active (cell_active),
    .cursor      (cursor),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         active;
    logic [7:0] code;
    logic [9:0] x;
    logic [9:0] y;
    bit         busy;
    bit         ready;
    bit         chk_cur;
    logic [3:0] cursor;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: buffers plus a few counters describing pending work.
  logic [7:0] m_shadow  [N];
  logic [7:0] m_display [N];
  int         m_cursor;
  bit         m_dirty;
  int         m_clear_left;
  bit         m_commit;
  bit         m_pending;
  bit         m_live;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i]  = 8'h20;
      m_display[i] = 8'h20;
    end
    m_cursor = 0; m_dirty = 0; m_clear_left = 0;
    m_commit = 0; m_pending = 0; m_live = 0;
  endtask

  // One clock: drive inputs at the falling edge, predict post-edge outputs.
  task automatic step(input bit rst, input bit v, input int c, input int ch,
                      input int p, input int x, input int y);
    exp_t e;
    bit   vb;
    bit   acc;
    @(negedge clk);
    botonRST       = rst;
    wr_if.wr_valid = v;
    wr_if.wr_cmd   = cmd_t'(c[1:0]);
    wr_if.wr_char  = ch[7:0];
    wr_if.wr_pos   = p[3:0];
    counterX       = x[12:0];
    counterY       = y[12:0];
    vb = (y == VA) && (x == 0);
    if (rst) begin
      e.active = 0; e.code = 8'h20; e.x = 10'(X0); e.y = 10'(Y0);
      model_reset();
    end else begin
      if (x >= X0 && x < X0 + N * W && y >= Y0 && y < Y0 + H) begin
        e.active = 1;
        e.code   = m_display[(x - X0) / W];
        e.x      = 10'(X0 + ((x - X0) / W) * W);
      end else begin
        e.active = 0; e.code = 8'h20; e.x = 10'(X0);
      end
      e.y = 10'(Y0);
      if (m_commit) begin
        for (int i = 0; i < N; i++) m_display[i] = m_shadow[i];
        m_dirty = 0; m_pending = 0; m_commit = 0;
      end else if (m_clear_left > 0) begin
        if (vb) m_pending = 1;
        m_clear_left--;
        if (m_clear_left == 0) begin
          m_cursor = 0; m_dirty = 1;
          if (m_pending) m_commit = 1;
        end
      end else begin
        acc = v && m_live;
        if (acc && c == 2) begin
          for (int i = 0; i < N; i++) m_shadow[i] = 8'h20;
          m_clear_left = N;
          m_pending    = vb;
        end else begin
          if (acc && c == 0) begin
            m_shadow[m_cursor] = ch[7:0];
            m_cursor = (m_cursor + 1) % N;
            m_dirty  = 1;
          end else if (acc && c == 1) begin
            m_cursor = p;
          end
          if (vb && m_dirty) m_commit = 1;
        end
      end
      m_live = 1;
    end
    e.busy    = (m_clear_left > 0) || m_commit;
    e.ready   = m_live && !e.busy;
    e.chk_cur = (m_clear_left == 0);
    e.cursor  = 4'(m_cursor);
    exp_q.push_back(e);
  endtask

  task automatic probe(input int x, input int y);
    step(0, 0, 3, 0, 0, x, y);
  endtask

  task automatic cmd(input int c, input int ch, input int p);
    step(0, 1, c, ch, p, 200, 200);
  endtask

  task automatic vblank_ev();
    step(0, 0, 3, 0, 0, 0, VA);
  endtask

  // Monitor: each cycle's prediction is compared just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cell_active", 32'(cell_active),   32'(e.active));
        check("char_code",   32'(char_code),     32'(e.code));
        check("char_x",      32'(char_x),        32'(e.x));
        check("char_y",      32'(char_y),        32'(e.y));
        check("busy",        32'(busy),          32'(e.busy));
        check("wr_ready",    32'(wr_if.wr_ready), 32'(e.ready));
        if (e.chk_cur) check("cursor", 32'(cursor), 32'(e.cursor));
      end
    end
  end

  initial begin
    int r;
    int c;
    int x;
    int y;
    botonRST = 1'b1; wr_if.wr_valid = 1'b0; wr_if.wr_cmd = CMD_NOP;
    wr_if.wr_char = 8'h00; wr_if.wr_pos = 4'd0; counterX = '0; counterY = '0;
    model_reset();

    step(1, 0, 3, 0, 0, 106, 80);
    step(1, 0, 3, 0, 0, 106, 80);
    probe(106, 80);

    // "HI", a frame boundary, then look at both cells and the line edges.
    cmd(0, 8'h48, 0);
    cmd(0, 8'h49, 0);
    probe(106, 80);
    vblank_ev();
    probe(200, 200);
    probe(106, 80); probe(122, 80); probe(121, 95); probe(361, 80);
    probe(105, 80); probe(362, 80); probe(106, 96); probe(106, 79);

    // Write while the line is being scanned; display must hold until vblank.
    cmd(1, 0, 5);
    step(0, 1, 0, 8'h41, 0, 186, 85);
    for (int i = 0; i < 6; i++) probe(106 + i * 16, 85);
    vblank_ev();
    probe(186, 85);
    probe(186, 85);

    // Cursor wrap from the last cell.
    cmd(1, 0, 15);
    cmd(0, 8'h5A, 0);
    cmd(0, 8'h42, 0);
    vblank_ev();
    probe(346, 80); probe(106, 80); probe(122, 80);

    // Clear with a vblank event arriving part-way through it.
    cmd(2, 0, 0);
    for (int i = 0; i < 4; i++) probe(106, 80);
    vblank_ev();
    for (int i = 0; i < 14; i++) probe(106 + i * 16, 80);
    probe(122, 80);

    // Refill, then reset while clearing entry 7.
    cmd(0, 8'h31, 0); cmd(0, 8'h32, 0);
    vblank_ev(); probe(106, 80);
    cmd(2, 0, 0);
    for (int i = 0; i < 7; i++) probe(122, 80);
    step(1, 0, 3, 0, 0, 122, 80);
    probe(106, 80); probe(122, 80);
    cmd(0, 8'h55, 0);
    vblank_ev(); probe(106, 80); probe(122, 80);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) begin x = 0; y = VA; end
      else begin x = int'($urandom_range(90, 380)); y = int'($urandom_range(70, 100)); end
      r = int'($urandom_range(0, 31));
      if (r == 0) c = 2;
      else begin
        r = int'($urandom_range(0, 3));
        c = (r == 2) ? 0 : r;
      end
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 1) == 1), c,
           int'($urandom_range(8'h21, 8'h7e)), int'($urandom_range(0, 15)), x, y);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_line_scheduler.md
Name: text_line_scheduler

Overview:
- Sequences a single printChar renderer across a row of NUM_CHARS character cells, driving one cell's char code and origin per pixel.
- The processor side loads characters into a shadow buffer through a valid/ready command port.
- The shadow buffer is copied to the display buffer at vertical-blank start, so a frame never shows a half-updated line.
- Sits between the CPU/IO bus and printChar inside topController.

Parameters:
- NUM_CHARS, 16, number of character cells in the line (power of 2)
- CHAR_W, 16, cell width in pixels (power of 2)
- CHAR_H, 16, cell height in pixels
- X0, 106, left pixel of cell 0
- Y0, 80, top pixel of the line
- V_ACTIVE, 480, first non-visible line (vblank start)

Ports:
- clk  in  1  pixel clock
- botonRST  in  1  synchronous active-high reset
- counterX  in  13  current pixel column
- counterY  in  13  current pixel row
- wr_valid  in  1  command valid
- wr_ready  out  1  command accepted when wr_valid&&wr_ready
- wr_cmd  in  2  00 write-at-cursor, 01 set-cursor, 10 clear, 11 nop
- wr_char  in  8  ASCII code for write
- wr_pos  in  $clog2(NUM_CHARS)  cursor target for set-cursor
- char_code  out  8  ASCII code to printChar
- char_x  out  10  cell origin X to printChar
- char_y  out  10  cell origin Y to printChar
- cell_active  out  1  current pixel lies inside the text line
- cursor  out  $clog2(NUM_CHARS)  current write cursor
- busy  out  1  clear or commit in progress

Behaviour:
- Single clock; reset is synchronous and active-high on botonRST, sampled on the clk rising edge.
- Reset values:
  - shadow and display buffers all 8'h20
  - cursor 0, dirty 0, FSM IDLE
  - wr_ready 0 during the reset cycle, 1 from the first cycle after
  - char_code 8'h20, char_x X0, char_y Y0, cell_active 0, busy 0
- Reset mid-clear or mid-commit aborts the operation immediately.
- FSM states: IDLE, CLEAR, COMMIT.
- IDLE (wr_ready=1):
  - write: shadow[cursor] <= wr_char; cursor <= cursor+1, wrapping NUM_CHARS-1 to 0; dirty <= 1.
  - set-cursor: cursor <= wr_pos.
  - clear: go to CLEAR, wr_ready <= 0.
  - nop: accepted, no effect.
- CLEAR (busy=1, wr_ready=0):
  - One shadow entry per cycle becomes 8'h20, index 0..NUM_CHARS-1, so CLEAR lasts NUM_CHARS cycles.
  - Then cursor <= 0, dirty <= 1, return to IDLE.
- Vblank event: single cycle where counterY==V_ACTIVE && counterX==0.
  - If dirty and in IDLE, go to COMMIT on the next cycle.
  - If in CLEAR, set commit_pending; COMMIT follows immediately after CLEAR completes.
- A write accepted in the vblank-event cycle is included in the commit.
- COMMIT (busy=1, wr_ready=0): lasts 1 cycle; display <= shadow (all entries), dirty <= 0, commit_pending <= 0, return to IDLE.
- Render path:
  - Registered; latency exactly 1 cycle from counterX/counterY to all render outputs.
  - In-line condition: X0 <= counterX < X0+NUM_CHARS*CHAR_W and Y0 <= counterY < Y0+CHAR_H.
  - When in-line: cell_active=1, idx=(counterX-X0)>>log2(CHAR_W), char_code=display[idx], char_x=X0+idx*CHAR_W, char_y=Y0.
  - Otherwise: cell_active=0, char_code=8'h20, char_x=X0, char_y=Y0.
  - Subtraction is done in 13 bits; char_x and char_y are truncated to 10 bits.
- The render path never reads the shadow buffer; display changes only in COMMIT.

Decomposition:
- Package text_pkg:
  - cmd_t enum (CMD_WRITE, CMD_SETCUR, CMD_CLEAR, CMD_NOP)
  - state_t enum (IDLE, CLEAR, COMMIT)
  - constant ASCII_SPACE=8'h20
- Sub-module text_cell_decode: combinational pixel-to-cell decoder (in-line flag, idx, char_x). The scheduler registers its outputs.

Test Plan:
- Reset, then write 'H','I' (8'h48, 8'h49), then one frame passes → after the vblank commit, counterX=106, counterY=80 gives char_code 8'h48, char_x 106 one cycle later; counterX=122 gives 8'h49, char_x 122.
- Write 8'h41 mid-frame while scanning the line → display stays 8'h20 until the counterY=480, counterX=0 event; busy is high for exactly 1 cycle; the next frame shows 8'h41.
- set-cursor 15, then write 8'h5A, 8'h42 → shadow[15]=8'h5A, shadow[0]=8'h42, cursor=1 (wrap).
- clear command → wr_ready low for 16 cycles, all cells 8'h20 after commit, cursor 0; a vblank event during clear → COMMIT occurs in the cycle after clear ends.
- Pixel at counterX=105 or 362, or counterY=96 → cell_active 0, char_code 8'h20.
- botonRST asserted during CLEAR at entry 7 → next cycle: all buffers 8'h20, FSM IDLE, wr_ready 1 one cycle after reset deasserts.
